// File: rtl/regfile_port_arbiter.sv
// Two-requester arbiter in front of a single-ported register file (one read or one write per transaction).
// Latency: the grant edge issues the access; ack follows 2 edges later for a read and 1 edge later for a write.
// Backpressure: requesters hold req until ack; no grants while busy, and none on the DONE->IDLE edge.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req*/we*/reg*/wdata*/restore*   per-requester transaction inputs
//   ack*/rdata*               per-requester one-cycle completion pulse and last read result
//   rf_read_*/rf_write_*      register-file access strobes and payload; rf_read_value is the read data
//   busy                      high whenever the FSM is not in IDLE
//
// Build option: define REGARB_FIXED_PRIORITY_EN to make requester 0 always win a tie
// (the round-robin last_grant bit is then not built).
module regfile_port_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [3:0]        reg0,
    input  logic [3:0]        reg1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              restore0,
    input  logic              restore1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rf_read_en,
    output logic [3:0]        rf_read_reg,
    output logic              rf_write_en,
    output logic [3:0]        rf_write_reg,
    output logic [DATA_W-1:0] rf_write_value,
    output logic              rf_write_restore_from_SPSR,
    input  logic [DATA_W-1:0] rf_read_value,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR,
        DONE
    } state_t;

    state_t r_state;
    logic   r_win;      // 0 = requester 0 owns the transaction in flight, 1 = requester 1

    logic              w_win;
    logic              w_we;
    logic [3:0]        w_reg;
    logic [DATA_W-1:0] w_wdata;
    logic              w_restore;

`ifdef REGARB_FIXED_PRIORITY_EN
    // Requester 1 only wins when requester 0 is idle.
    assign w_win = ~req0;
`else
    logic r_last_grant;

    // On a tie the requester that did not win last time goes next;
    // a lone requester always wins.
    assign w_win = (req0 & req1) ? ~r_last_grant : req1;
`endif

    assign w_we      = w_win ? we1      : we0;
    assign w_reg     = w_win ? reg1     : reg0;
    assign w_wdata   = w_win ? wdata1   : wdata0;
    assign w_restore = w_win ? restore1 : restore0;

    assign busy = (r_state != IDLE);

    // The request fields are captured straight into the rf_* registers on the
    // grant edge, so later changes on the requester side have no effect until DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state                    <= IDLE;
            r_win                      <= 1'b0;
`ifndef REGARB_FIXED_PRIORITY_EN
            r_last_grant               <= 1'b1;
`endif
            ack0                       <= 1'b0;
            ack1                       <= 1'b0;
            rdata0                     <= '0;
            rdata1                     <= '0;
            rf_read_en                 <= 1'b0;
            rf_read_reg                <= '0;
            rf_write_en                <= 1'b0;
            rf_write_reg               <= '0;
            rf_write_value             <= '0;
            rf_write_restore_from_SPSR <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0 | req1) begin
                        r_win        <= w_win;
`ifndef REGARB_FIXED_PRIORITY_EN
                        r_last_grant <= w_win;
`endif
                        if (w_we) begin
                            rf_write_en                <= 1'b1;
                            rf_write_reg               <= w_reg;
                            rf_write_value             <= w_wdata;
                            rf_write_restore_from_SPSR <= w_restore;
                            r_state                    <= WR;
                        end else begin
                            rf_read_en  <= 1'b1;
                            rf_read_reg <= w_reg;
                            r_state     <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    rf_read_en <= 1'b0;
                    r_state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Register file returns data two edges after the read strobe was registered.
                    if (r_win) begin
                        rdata1 <= rf_read_value;
                        ack1   <= 1'b1;
                    end else begin
                        rdata0 <= rf_read_value;
                        ack0   <= 1'b1;
                    end
                    r_state <= DONE;
                end
                WR: begin
                    rf_write_en <= 1'b0;
                    if (r_win) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    // Deliberately no grant here: requesters get one cycle to drop req after ack.
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

    localparam int          DATA_W = 32;
    localparam logic [31:0] JUNK   = 32'hBAD0_0BAD;

    typedef struct {
        bit          id;
        bit          we;
        logic [3:0]  rg;
        logic [31:0] val;     // write data for writes, register-file data for reads
        bit          restore;
    } item_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1, we0, we1, restore0, restore1;
    logic [3:0]        reg0, reg1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1, busy;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              rf_read_en, rf_write_en, rf_write_restore_from_SPSR;
    logic [3:0]        rf_read_reg, rf_write_reg;
    logic [DATA_W-1:0] rf_write_value;
    logic [DATA_W-1:0] rf_read_value;

    int    checks = 0;
    int    errors = 0;
    item_t exp_q[$];

    always #5 clk = ~clk;

    regfile_port_arbiter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .reg0(reg0), .reg1(reg1), .wdata0(wdata0), .wdata1(wdata1),
        .restore0(restore0), .restore1(restore1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .rf_read_en(rf_read_en), .rf_read_reg(rf_read_reg),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg),
        .rf_write_value(rf_write_value),
        .rf_write_restore_from_SPSR(rf_write_restore_from_SPSR),
        .rf_read_value(rf_read_value),
        .busy(busy)
    );

    function automatic void push_exp(bit id, bit we, logic [3:0] rg, logic [31:0] val, bit restore);
        item_t it;
        it.id = id; it.we = we; it.rg = rg; it.val = val; it.restore = restore;
        exp_q.push_back(it);
    endfunction

    // ---------------- scoreboard monitor ----------------
    int          cyc = 0;
    int          t0 = 0;
    bit          in_txn = 0;
    item_t       cur;
    logic        prev_rd = 0, prev_wr = 0;
    logic [31:0] mdl_rd0 = 0, mdl_rd1 = 0;

    initial rf_read_value = JUNK;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_txn        = 0;
            mdl_rd0       = 0;
            mdl_rd1       = 0;
            prev_rd       = 0;
            prev_wr       = 0;
            rf_read_value = JUNK;
        end else begin
            checks++;
            if (rf_read_en && rf_write_en) begin
                errors++; $display("FAIL rd_wr_overlap: both rf_read_en and rf_write_en high at cycle %0d, required at most one", cyc);
            end
            if ((rf_read_en && !prev_rd) || (rf_write_en && !prev_wr)) begin
                checks++;
                if (in_txn || exp_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_grant: access started at cycle %0d, required none (in_txn=%0d queued=%0d)", cyc, in_txn, exp_q.size());
                end else begin
                    cur    = exp_q.pop_front();
                    in_txn = 1;
                    t0     = cyc;
                    checks++;
                    if (rf_write_en !== cur.we) begin
                        errors++; $display("FAIL grant_kind: rf_write_en=%0b required %0b (requester %0d)", rf_write_en, cur.we, cur.id);
                    end else if (cur.we) begin
                        checks++;
                        if ({rf_write_reg, rf_write_value, rf_write_restore_from_SPSR} !== {cur.rg, cur.val, cur.restore}) begin
                            errors++; $display("FAIL write_payload: reg=%0d val=%h restore=%0b required reg=%0d val=%h restore=%0b",
                                rf_write_reg, rf_write_value, rf_write_restore_from_SPSR, cur.rg, cur.val, cur.restore);
                        end
                    end else begin
                        checks++;
                        if (rf_read_reg !== cur.rg) begin
                            errors++; $display("FAIL read_reg: rf_read_reg=%0d required %0d", rf_read_reg, cur.rg);
                        end
                    end
                end
            end
            if (in_txn && cyc == t0 + 1) begin
                checks++;
                if (rf_read_en || rf_write_en) begin
                    errors++; $display("FAIL strobe_width: strobe still high one cycle after grant (rd=%0b wr=%0b), required low", rf_read_en, rf_write_en);
                end
                // Valid read data only appears for the edge two after the strobe edge.
                if (!cur.we) rf_read_value = cur.val;
            end
            if (ack0 || ack1) begin
                checks++;
                if (!in_txn) begin
                    errors++; $display("FAIL spurious_ack: ack0=%0b ack1=%0b at cycle %0d, required no ack", ack0, ack1, cyc);
                end else begin
                    // Count cycles with the grant-edge cycle as cycle 1.
                    checks++;
                    if (cyc - t0 + 1 !== (cur.we ? 2 : 3)) begin
                        errors++; $display("FAIL ack_latency: %0d cycles required %0d", cyc - t0 + 1, cur.we ? 2 : 3);
                    end
                    checks++;
                    if ({ack1, ack0} !== (cur.id ? 2'b10 : 2'b01)) begin
                        errors++; $display("FAIL ack_owner: {ack1,ack0}=%b required requester %0d", {ack1, ack0}, cur.id);
                    end
                    if (!cur.we) begin
                        if (cur.id) mdl_rd1 = cur.val; else mdl_rd0 = cur.val;
                    end
                    rf_read_value = JUNK;
                    in_txn        = 0;
                end
            end
            if (in_txn && cyc > t0 + 3) begin
                errors++; $display("FAIL ack_missing: no ack %0d cycles after grant, required ack", cyc - t0);
                in_txn        = 0;
                rf_read_value = JUNK;
            end
            checks++;
            if (rdata0 !== mdl_rd0 || rdata1 !== mdl_rd1) begin
                errors++; $display("FAIL rdata_model: rdata0=%h rdata1=%h required %h %h", rdata0, rdata1, mdl_rd0, mdl_rd1);
            end
            prev_rd = rf_read_en;
            prev_wr = rf_write_en;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; req0 = 1; req1 = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack0, ack1, busy, rf_read_en, rf_write_en, rf_write_restore_from_SPSR} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: ack0 ack1 busy rd wr rst=%b required 000000",
                {ack0, ack1, busy, rf_read_en, rf_write_en, rf_write_restore_from_SPSR});
        end
        checks++;
        if (rdata0 !== 0 || rdata1 !== 0 || rf_write_value !== 0 || rf_read_reg !== 0 || rf_write_reg !== 0) begin
            errors++; $display("FAIL reset_data: rdata0=%h rdata1=%h wval=%h rreg=%0d wreg=%0d required all 0",
                rdata0, rdata1, rf_write_value, rf_read_reg, rf_write_reg);
        end
        req0 = 0; req1 = 0;
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 0) begin
            errors++; $display("FAIL idle_after_reset: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_read();
        bit got = 0;
        int n_rd = 0;
        push_exp(0, 0, 4'd3, 32'hDEAD_BEEF, 0);
        we0 = 0; reg0 = 4'd3; req0 = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rf_read_en) n_rd++;
            if (ack0) begin got = 1; break; end
        end
        req0 = 0;
        checks++;
        if (!got) begin errors++; $display("FAIL read_timeout: ack0=0 after 20 cycles, required 1"); end
        checks++;
        if (n_rd !== 1) begin errors++; $display("FAIL read_pulses: rf_read_en high %0d cycles required 1", n_rd); end
        checks++;
        if (rdata0 !== 32'hDEAD_BEEF || rdata1 !== 0) begin
            errors++; $display("FAIL read_result: rdata0=%h rdata1=%h required deadbeef 00000000", rdata0, rdata1);
        end
        @(negedge clk);
        checks++;
        if (ack0 !== 0 || busy !== 0) begin errors++; $display("FAIL read_ack_width: ack0=%0b busy=%0b required 0 0", ack0, busy); end
    endtask

    task automatic test_write();
        bit got = 0;
        int n_wr = 0, n_rd = 0;
        push_exp(1, 1, 4'd15, 32'h1234_5678, 1);
        we1 = 1; reg1 = 4'd15; wdata1 = 32'h1234_5678; restore1 = 1; req1 = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rf_write_en) n_wr++;
            if (rf_read_en) n_rd++;
            if (ack1) begin got = 1; break; end
        end
        req1 = 0; restore1 = 0;
        checks++;
        if (!got) begin errors++; $display("FAIL write_timeout: ack1=0 after 20 cycles, required 1"); end
        checks++;
        if (n_wr !== 1 || n_rd !== 0) begin
            errors++; $display("FAIL write_pulses: rf_write_en %0d cycles, rf_read_en %0d cycles, required 1 and 0", n_wr, n_rd);
        end
        checks++;
        if (rdata0 !== 32'hDEAD_BEEF || rdata1 !== 0) begin
            errors++; $display("FAIL write_keeps_rdata: rdata0=%h rdata1=%h required deadbeef 00000000", rdata0, rdata1);
        end
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        bit got = 0, seen = 0;
        push_exp(0, 0, 4'd7, 32'hA5A5_0001, 0);
        we0 = 0; reg0 = 4'd7; req0 = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rf_read_en) begin seen = 1; break; end
        end
        req0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack0) begin got = 1; break; end
        end
        checks++;
        if (!seen || !got) begin errors++; $display("FAIL drop_ack: grant=%0b ack=%0b required 1 1", seen, got); end
        checks++;
        if (rdata0 !== 32'hA5A5_0001) begin errors++; $display("FAIL drop_rdata: rdata0=%h required a5a50001", rdata0); end
        @(negedge clk);
    endtask

    task automatic test_rdata_hold();
        bit got = 0;
        push_exp(1, 0, 4'd2, 32'h1111_2222, 0);
        we1 = 0; reg1 = 4'd2; req1 = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack1) begin got = 1; break; end
        end
        req1 = 0;
        checks++;
        if (!got || rdata1 !== 32'h1111_2222 || rdata0 !== 32'hA5A5_0001) begin
            errors++; $display("FAIL hold_other_read: ack=%0b rdata0=%h rdata1=%h required 1 a5a50001 11112222", got, rdata0, rdata1);
        end
        @(negedge clk);
        got = 0;
        push_exp(0, 1, 4'd1, 32'hCAFE_0000, 0);
        we0 = 1; reg0 = 4'd1; wdata0 = 32'hCAFE_0000; req0 = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack0) begin got = 1; break; end
        end
        req0 = 0; we0 = 0;
        checks++;
        if (!got || rdata0 !== 32'hA5A5_0001 || rdata1 !== 32'h1111_2222) begin
            errors++; $display("FAIL hold_own_write: ack=%0b rdata0=%h rdata1=%h required 1 a5a50001 11112222", got, rdata0, rdata1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got = 0, seen = 0;
        push_exp(0, 0, 4'd4, 32'h4444_4444, 0);
        we0 = 0; reg0 = 4'd4; req0 = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rf_read_en) begin seen = 1; break; end
        end
        @(negedge clk);            // now in RD_WAIT
        rst = 1; req0 = 0;
        #1;
        checks++;
        if (!seen || ack0 !== 0 || rf_read_en !== 0 || busy !== 0 || rdata0 !== 0) begin
            errors++; $display("FAIL mid_reset: grant=%0b ack0=%0b rd=%0b busy=%0b rdata0=%h required 1 0 0 0 0",
                seen, ack0, rf_read_en, busy, rdata0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== 0 || rf_read_en !== 0) begin
                errors++; $display("FAIL mid_reset_hold: ack0=%0b rd=%0b required 0 0", ack0, rf_read_en);
            end
        end
        rst = 0;
        @(negedge clk);
        push_exp(0, 0, 4'd4, 32'h0BAD_F00D, 0);
        req0 = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack0) begin got = 1; break; end
        end
        req0 = 0;
        checks++;
        if (!got || rdata0 !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL after_reset_read: ack=%0b rdata0=%h required 1 0badf00d", got, rdata0);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n = 0, since = -1;
        rst = 1;
        we0 = 0; reg0 = 4'd5;
        we1 = 1; reg1 = 4'd9; wdata1 = 32'h9999_0009; restore1 = 0;
`ifdef REGARB_FIXED_PRIORITY_EN
        push_exp(0, 0, 4'd5, 32'h5000_0001, 0);
        push_exp(0, 0, 4'd5, 32'h5000_0002, 0);
        push_exp(0, 0, 4'd5, 32'h5000_0003, 0);
        push_exp(0, 0, 4'd5, 32'h5000_0004, 0);
`else
        push_exp(0, 0, 4'd5, 32'h5000_0001, 0);
        push_exp(1, 1, 4'd9, 32'h9999_0009, 0);
        push_exp(0, 0, 4'd5, 32'h5000_0003, 0);
        push_exp(1, 1, 4'd9, 32'h9999_0009, 0);
`endif
        req0 = 1; req1 = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (since == 0) begin
                checks++;
                if (busy !== 0) begin errors++; $display("FAIL b2b_gap: busy=%0b one cycle after ack required 0", busy); end
            end
            if (since == 1) begin
                checks++;
                if (busy !== 1) begin errors++; $display("FAIL b2b_regrant: busy=%0b two cycles after ack required 1", busy); end
            end
            if (since >= 0) since++;
            if (ack0 || ack1) begin
                n++;
                since = 0;
                if (n == 4) begin req0 = 0; req1 = 0; end
            end
        end
        req0 = 0; req1 = 0;
        checks++;
        if (n !== 4 || exp_q.size() !== 0) begin
            errors++; $display("FAIL b2b_count: acks=%0d left_in_queue=%0d required 4 0", n, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; restore0 = 0; restore1 = 0;
        reg0 = 0; reg1 = 0; wdata0 = 0; wdata1 = 0;
        test_reset();
        test_read();
        test_write();
        test_drop_req();
        test_rdata_hold();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL leftover: %0d expected transactions never granted, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule
